// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer scanout reader.
package fb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam int DEF_LINE_WORDS = 160;
    localparam int DEF_LINES      = 120;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_fifo.sv
// Synchronous read buffer with first-word-fall-through head and flush.
module fb_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign empty  = (count == '0);
    assign pop_ok = pop & ~empty;
    assign rdata  = mem[rd_ptr];

    // Writes are not gated on full: the reader's credit check prevents overflow.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout reader: sequential SRAM fetch into a FIFO, presented
// to the pixel pipeline with end-of-line / end-of-frame tags.
module fb_scanout
    import fb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h0000,
    parameter int                LINE_WORDS = DEF_LINE_WORDS,
    parameter int                LINES      = DEF_LINES,
    parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              cpu_busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] data_in_pins,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              underrun
);

    localparam int TOTAL = LINE_WORDS * LINES;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int COL_W = $clog2(LINE_WORDS + 1);
    localparam int ROW_W = $clog2(LINES + 1);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WORDS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINES - 1);

    fb_state_t        state;
    fb_state_t        state_nxt;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] pops;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             inflight;
    logic             pop;
    logic             credit_ok;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;

    // A word returning in the same cycle as frame_start belongs to the old frame.
    fb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (inflight & ~frame_start),
        .wdata (data_in_pins),
        .pop   (pop),
        .rdata (pix_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign pix_valid = ~fifo_empty;
    assign pop       = pix_valid & pix_ready;
    assign pix_eol   = pix_valid & (col == COL_LAST);
    assign pix_eof   = pix_eol & (row == ROW_LAST);
    assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign rd_addr   = BASE_ADDR + ADDR_W'(issued);

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rd_en = ~cpu_busy & credit_ok & (issued < TOTAL_C);
                if (issued == TOTAL_C) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight && (pops == TOTAL_C)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (frame_start) begin
            state_nxt = ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            issued   <= '0;
            pops     <= '0;
            col      <= '0;
            row      <= '0;
            inflight <= 1'b0;
            underrun <= 1'b0;
        end else if (frame_start) begin
            state    <= state_nxt;
            issued   <= '0;
            pops     <= '0;
            col      <= '0;
            row      <= '0;
            inflight <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en;
            if (rd_en) begin
                issued <= issued + 1'b1;
            end
            if (pop) begin
                pops <= pops + 1'b1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if ((state != ST_IDLE) && pix_ready && !pix_valid && (pops < TOTAL_C)) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: directed scenarios plus randomized traffic.
module tb_fb_scanout;
    import fb_pkg::*;

    localparam logic [15:0] BASE  = 16'hFFFC;
    localparam int          LW    = 4;
    localparam int          NL    = 3;
    localparam int          DEPTH = 8;
    localparam int          TOTAL = LW * NL;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        cpu_busy;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [15:0] data_in_pins;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_eol;
    logic        pix_eof;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic        eol;
        logic        eof;
    } exp_t;

    exp_t        sb[$];
    int          n_issued = 0;
    int          n_popped = 0;
    bit          started = 0;
    bit          exp_underrun = 0;
    bit          held_valid = 0;
    logic [15:0] held_data;
    logic        held_eol;
    logic        held_eof;

    fb_scanout #(
        .BASE_ADDR  (BASE),
        .LINE_WORDS (LW),
        .LINES      (NL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .cpu_busy     (cpu_busy),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .data_in_pins (data_in_pins),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_eol      (pix_eol),
        .pix_eof      (pix_eof),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sram_word(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // SRAM: data for a read appears the cycle after rd_en; junk otherwise.
    always @(posedge clk) begin
        if (rd_en) data_in_pins <= sram_word(rd_addr);
        else       data_in_pins <= 16'($urandom);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor and reference model: a frame is TOTAL words at BASE+k, tagged by k.
    always @(negedge clk) begin
        exp_t e;
        check("underrun", underrun, exp_underrun);
        if (held_valid) begin
            check("hold_valid", pix_valid, 1'b1);
            check("hold_data", pix_data, held_data);
            check("hold_eol", pix_eol, held_eol);
            check("hold_eof", pix_eof, held_eof);
        end
        if (rd_en) begin
            if (!started || n_issued >= TOTAL) begin
                checks++; errors++;
                $display("FAIL extra_read: rd_en with %0d reads already issued (active=%0d)", n_issued, started);
            end else begin
                check("rd_addr", rd_addr, 32'(16'(BASE + 16'(n_issued))));
                n_issued++;
                check("credit", 32'((n_issued - n_popped) <= DEPTH), 32'd1);
            end
        end
        if (pix_valid && pix_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pop: got data %0h, expected no transfer", pix_data);
            end else begin
                e = sb.pop_front();
                check("pix_data", pix_data, e.data);
                check("pix_eol", pix_eol, e.eol);
                check("pix_eof", pix_eof, e.eof);
            end
            n_popped++;
        end
        held_valid = pix_valid && !pix_ready && !frame_start && !rst;
        held_data  = pix_data;
        held_eol   = pix_eol;
        held_eof   = pix_eof;
        if (rst) begin
            sb.delete();
            n_issued = 0; n_popped = 0; started = 0; exp_underrun = 0;
        end else if (frame_start) begin
            sb.delete();
            for (int k = 0; k < TOTAL; k++) begin
                e.data = sram_word(16'(BASE + 16'(k)));
                e.eol  = (k % LW) == LW - 1;
                e.eof  = (k == TOTAL - 1);
                sb.push_back(e);
            end
            n_issued = 0; n_popped = 0; started = 1; exp_underrun = 0;
        end else if (started && n_popped < TOTAL && pix_ready && !pix_valid) begin
            exp_underrun = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the cycle right after the frame_start cycle.
    task automatic pulse_fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic drain(input string name);
        cpu_busy  = 1'b0;
        pix_ready = 1'b1;
        repeat (40) step();
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        @(negedge clk);
        check({name, "_rd_en"}, rd_en, 1'b0);
        check({name, "_rd_addr"}, rd_addr, BASE);
        check({name, "_valid"}, pix_valid, 1'b0);
        check({name, "_eol"}, pix_eol, 1'b0);
        check({name, "_eof"}, pix_eof, 1'b0);
        check({name, "_underrun"}, underrun, 1'b0);
    endtask

    initial begin
        int cnt;
        int budget;
        rst = 1'b1; frame_start = 1'b0; cpu_busy = 1'b0; pix_ready = 1'b0;
        repeat (3) step();
        check_reset_values("reset");
        step();
        rst = 1'b0;
        repeat (3) step();

        // Full-rate frame: back-to-back reads, first word two cycles after the first read.
        pix_ready = 1'b1;
        step();
        pulse_fs();
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i <= TOTAL) check("s1_rd_en", rd_en, 1'b1);
            check("s1_valid", pix_valid, 32'(i >= 3));
            step();
        end
        drain("s1_drained");

        // CPU holds the bus for cycles 2..5 after frame_start.
        step();
        pulse_fs();
        for (int i = 1; i <= 8; i++) begin
            cpu_busy = (i >= 2 && i <= 5);
            @(negedge clk);
            check("s2_rd_en", rd_en, 32'(!(i >= 2 && i <= 5)));
            step();
        end
        drain("s2_drained");

        // Stalled consumer: reads stop once the buffer credit is used up.
        pix_ready = 1'b0;
        step();
        pulse_fs();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_en) cnt++;
            step();
        end
        check("s3_read_count", 32'(cnt), 32'(DEPTH));
        @(negedge clk);
        check("s3_rd_en_idle", rd_en, 1'b0);
        drain("s3_drained");

        // Restart after three words, with a read in flight.
        step();
        pulse_fs();
        budget = 30;
        while (n_popped < 3 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++; errors++;
            $display("FAIL s4_wait: popped %0d words, expected 3 within 30 cycles", n_popped);
        end
        step();
        pulse_fs();
        drain("s4_drained");

        // Bus starved for the whole frame: underrun sets, then clears on restart.
        cpu_busy = 1'b1;
        step();
        pulse_fs();
        repeat (6) step();
        @(negedge clk);
        check("s5_underrun_set", underrun, 1'b1);
        pix_ready = 1'b0;
        step();
        pulse_fs();
        @(negedge clk);
        check("s5_underrun_clr", underrun, 1'b0);
        drain("s5_drained");

        // Randomized traffic with occasional restarts.
        for (int c = 0; c < 3000; c++) begin
            cpu_busy  = ($urandom_range(0, 99) < 30);
            pix_ready = ($urandom_range(0, 99) < 70);
            if (!started || n_popped >= TOTAL)
                frame_start = ($urandom_range(0, 99) < 20);
            else
                frame_start = ($urandom_range(0, 199) == 0);
            step();
        end
        frame_start = 1'b0;
        drain("rand_drained");

        // Reset in the middle of a frame.
        step();
        pulse_fs();
        repeat (5) step();
        rst = 1'b1;
        step();
        check_reset_values("midrst");
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_read", rd_en, 1'b0);
            check("midrst_no_valid", pix_valid, 1'b0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
